// File: rtl/pc_redirect_unit.sv
// Fetch PC sequencer: sequential advance, branch/JALR redirect with a post-redirect
// shadow window, and a sticky halt on misaligned redirect targets.
module pc_redirect_unit #(
    parameter logic [31:0] RESET_VECTOR  = 32'h0000_0000,
    parameter int unsigned SHADOW_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  branch_ctrl,
    input  logic [31:0] branch_target,
    input  logic [31:0] alu_out,
    input  logic        stall,
    input  logic        imem_ready,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        if_flush,
    output logic        id_flush,
    output logic        misalign_err,
    output logic        halted
);

    localparam int unsigned CNT_W = (SHADOW_CYCLES < 2) ? 1 : $clog2(SHADOW_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_SHADOW,
        ST_HALT
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  shadow_cnt;
    logic [CNT_W-1:0]  shadow_cnt_next;
    logic [31:0]       pc_next;
    logic              misalign_next;

    logic              is_branch;
    logic              is_jalr;
    logic              redirect;
    logic [31:0]       target;
    logic              target_misaligned;
    logic              misalign;
    logic              take_redirect;
    logic              advance;

    assign is_branch         = (branch_ctrl == 2'b01);
    assign is_jalr           = (branch_ctrl == 2'b10);
    assign redirect          = (state == ST_RUN) && (is_branch || is_jalr);
    assign target            = is_jalr ? {alu_out[31:1], 1'b0} : branch_target;
    assign target_misaligned = target[1] | target[0];
    assign misalign          = redirect && target_misaligned;
    assign take_redirect     = redirect && !target_misaligned;
    assign advance           = !stall && imem_ready;

    assign pc_plus4 = pc + 32'd4;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_RUN: begin
                if (misalign) begin
                    state_next = ST_HALT;
                end else if (take_redirect) begin
                    state_next = ST_SHADOW;
                end
            end
            ST_SHADOW: begin
                if (shadow_cnt == '0) begin
                    state_next = ST_RUN;
                end
            end
            ST_HALT:  state_next = ST_HALT;
            default:  state_next = ST_RUN;
        endcase
    end

    always_comb begin
        if_flush = rst && take_redirect;
        id_flush = rst && take_redirect;
        halted   = rst && (state == ST_HALT);
    end

    // Misalign wins over redirect, redirect over stall, stall over imem_ready.
    always_comb begin
        pc_next         = pc;
        shadow_cnt_next = shadow_cnt;
        misalign_next   = misalign_err;
        case (state)
            ST_RUN: begin
                if (misalign) begin
                    misalign_next = 1'b1;
                end else if (take_redirect) begin
                    pc_next         = target;
                    shadow_cnt_next = CNT_W'(SHADOW_CYCLES - 1);
                end else if (advance) begin
                    pc_next = pc_plus4;
                end
            end
            ST_SHADOW: begin
                if (shadow_cnt != '0) begin
                    shadow_cnt_next = shadow_cnt - 1'b1;
                end
                if (advance) begin
                    pc_next = pc_plus4;
                end
            end
            default: begin
                pc_next = pc;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc           <= RESET_VECTOR;
            shadow_cnt   <= '0;
            misalign_err <= 1'b0;
        end else begin
            pc           <= pc_next;
            shadow_cnt   <= shadow_cnt_next;
            misalign_err <= misalign_next;
        end
    end

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Self-checking bench for pc_redirect_unit: directed vector table, a back-to-back
// redirect sequence and a randomized run against a cycle-level reference model.
module tb_pc_redirect_unit;

    localparam logic [31:0] RV = 32'h0000_0000;
    localparam int unsigned SHADOW = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  branch_ctrl;
    logic [31:0] branch_target;
    logic [31:0] alu_out;
    logic        stall;
    logic        imem_ready;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        if_flush;
    logic        id_flush;
    logic        misalign_err;
    logic        halted;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pc_redirect_unit #(
        .RESET_VECTOR (RV),
        .SHADOW_CYCLES(SHADOW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .branch_ctrl  (branch_ctrl),
        .branch_target(branch_target),
        .alu_out      (alu_out),
        .stall        (stall),
        .imem_ready   (imem_ready),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .if_flush     (if_flush),
        .id_flush     (id_flush),
        .misalign_err (misalign_err),
        .halted       (halted)
    );

    typedef struct {
        logic        r;
        logic [1:0]  bc;
        logic [31:0] bt;
        logic [31:0] alu;
        logic        st;
        logic        rdy;
        logic        f;     // flushes in this cycle
        logic        h;     // halted in this cycle
        logic [31:0] pc;    // pc after the edge
        logic        e;     // misalign_err after the edge
    } vec_t;

    vec_t vt[$];

    function automatic vec_t v(input logic r, input logic [1:0] bc, input logic [31:0] bt,
                               input logic [31:0] alu, input logic st, input logic rdy,
                               input logic f, input logic h, input logic [31:0] epc,
                               input logic e);
        vec_t x;
        x.r = r; x.bc = bc; x.bt = bt; x.alu = alu; x.st = st; x.rdy = rdy;
        x.f = f; x.h = h; x.pc = epc; x.e = e;
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic [1:0] bc, input logic [31:0] bt,
                         input logic [31:0] alu, input logic st, input logic rdy);
        @(negedge clk);
        rst = r; branch_ctrl = bc; branch_target = bt; alu_out = alu;
        stall = st; imem_ready = rdy;
    endtask

    // Reference model: pc value, sticky error, halt flag, and how many more
    // cycles branch requests are to be ignored after a taken redirect.
    logic [31:0] m_pc;
    logic        m_err;
    logic        m_halt;
    int unsigned m_quiet;

    task automatic model_cycle(input logic r, input logic [1:0] bc, input logic [31:0] bt,
                               input logic [31:0] alu, input logic st, input logic rdy);
        logic [31:0] tgt;
        logic        jump;
        logic        exp_f;
        logic        exp_h;
        drive(r, bc, bt, alu, st, rdy);
        #1;
        exp_f = 1'b0;
        exp_h = r && m_halt;
        jump  = r && !m_halt && (m_quiet == 0) && (bc == 2'b01 || bc == 2'b10);
        tgt   = (bc == 2'b10) ? (alu & ~32'd1) : bt;
        if (jump && (tgt % 4) == 0) exp_f = 1'b1;
        chk("rnd_pc", pc, m_pc);
        chk("rnd_pc_plus4", pc_plus4, m_pc + 32'd4);
        chk("rnd_misalign_err", {31'b0, misalign_err}, {31'b0, m_err});
        chk("rnd_halted", {31'b0, halted}, {31'b0, exp_h});
        chk("rnd_if_flush", {31'b0, if_flush}, {31'b0, exp_f});
        chk("rnd_id_flush", {31'b0, id_flush}, {31'b0, exp_f});
        if (!r) begin
            m_pc = RV; m_err = 1'b0; m_halt = 1'b0; m_quiet = 0;
        end else if (!m_halt) begin
            if (jump && (tgt % 4) != 0) begin
                m_err = 1'b1; m_halt = 1'b1;
            end else if (jump) begin
                m_pc = tgt; m_quiet = SHADOW;
            end else begin
                if (m_quiet > 0) m_quiet--;
                if (!st && rdy) m_pc = m_pc + 32'd4;
            end
        end
        @(posedge clk);
    endtask

    initial begin
        rst = 1'b0; branch_ctrl = 2'b00; branch_target = '0; alu_out = '0;
        stall = 1'b0; imem_ready = 1'b1;

        //          r  bc     bt            alu           st rdy  f  h  pc            e
        vt.push_back(v(0, 2'b01, 32'h40,       32'h0,        0, 1, 0, 0, 32'h0,        0));
        vt.push_back(v(0, 2'b00, 32'h0,        32'h0,        0, 1, 0, 0, 32'h0,        0));
        vt.push_back(v(1, 2'b00, 32'h0,        32'h0,        0, 1, 0, 0, 32'h4,        0));
        vt.push_back(v(1, 2'b00, 32'h0,        32'h0,        0, 1, 0, 0, 32'h8,        0));
        vt.push_back(v(1, 2'b00, 32'h0,        32'h0,        0, 1, 0, 0, 32'hC,        0));
        vt.push_back(v(1, 2'b00, 32'h0,        32'h0,        0, 1, 0, 0, 32'h10,       0));
        vt.push_back(v(1, 2'b01, 32'h40,       32'h0,        0, 1, 1, 0, 32'h40,       0));
        vt.push_back(v(1, 2'b01, 32'h80,       32'h0,        0, 1, 0, 0, 32'h44,       0));
        vt.push_back(v(1, 2'b01, 32'h80,       32'h0,        0, 1, 0, 0, 32'h48,       0));
        // JALR 0x101: bit0 cleared gives aligned 0x100
        vt.push_back(v(1, 2'b10, 32'h0,        32'h101,      0, 1, 1, 0, 32'h100,      0));
        vt.push_back(v(1, 2'b00, 32'h0,        32'h0,        1, 1, 0, 0, 32'h100,      0));
        vt.push_back(v(1, 2'b00, 32'h0,        32'h0,        0, 0, 0, 0, 32'h100,      0));
        vt.push_back(v(1, 2'b01, 32'h200,      32'h0,        1, 1, 1, 0, 32'h200,      0));
        vt.push_back(v(1, 2'b00, 32'h0,        32'h0,        0, 1, 0, 0, 32'h204,      0));
        vt.push_back(v(1, 2'b00, 32'h0,        32'h0,        1, 1, 0, 0, 32'h204,      0));
        vt.push_back(v(1, 2'b00, 32'h0,        32'h0,        1, 1, 0, 0, 32'h204,      0));
        vt.push_back(v(1, 2'b00, 32'h0,        32'h0,        0, 0, 0, 0, 32'h204,      0));
        vt.push_back(v(1, 2'b11, 32'h40,       32'h0,        0, 1, 0, 0, 32'h208,      0));
        vt.push_back(v(1, 2'b01, 32'hFFFF_FFFC, 32'h0,       0, 1, 1, 0, 32'hFFFF_FFFC, 0));
        vt.push_back(v(1, 2'b00, 32'h0,        32'h0,        1, 1, 0, 0, 32'hFFFF_FFFC, 0));
        vt.push_back(v(1, 2'b00, 32'h0,        32'h0,        1, 1, 0, 0, 32'hFFFF_FFFC, 0));
        vt.push_back(v(1, 2'b00, 32'h0,        32'h0,        0, 1, 0, 0, 32'h0,        0));
        vt.push_back(v(1, 2'b00, 32'h0,        32'h0,        0, 1, 0, 0, 32'h4,        0));
        vt.push_back(v(1, 2'b10, 32'h0,        32'h106,      0, 1, 0, 0, 32'h4,        1));
        vt.push_back(v(1, 2'b01, 32'h40,       32'h0,        0, 1, 0, 1, 32'h4,        1));
        vt.push_back(v(1, 2'b00, 32'h0,        32'h0,        0, 1, 0, 1, 32'h4,        1));
        vt.push_back(v(0, 2'b01, 32'h40,       32'h0,        0, 1, 0, 0, 32'h0,        0));
        vt.push_back(v(1, 2'b01, 32'h40,       32'h0,        0, 1, 1, 0, 32'h40,       0));
        vt.push_back(v(0, 2'b01, 32'h80,       32'h0,        0, 1, 0, 0, 32'h0,        0));
        vt.push_back(v(1, 2'b01, 32'h80,       32'h0,        0, 1, 1, 0, 32'h80,       0));
        vt.push_back(v(1, 2'b00, 32'h0,        32'h0,        0, 1, 0, 0, 32'h84,       0));
        vt.push_back(v(1, 2'b00, 32'h0,        32'h0,        0, 1, 0, 0, 32'h88,       0));
        vt.push_back(v(1, 2'b01, 32'h301,      32'h0,        0, 1, 0, 0, 32'h88,       1));
        vt.push_back(v(0, 2'b01, 32'h40,       32'h0,        0, 1, 0, 0, 32'h0,        0));
        vt.push_back(v(1, 2'b00, 32'h0,        32'h0,        0, 1, 0, 0, 32'h4,        0));
        vt.push_back(v(0, 2'b01, 32'h40,       32'h0,        0, 1, 0, 0, 32'h0,        0));

        foreach (vt[i]) begin
            drive(vt[i].r, vt[i].bc, vt[i].bt, vt[i].alu, vt[i].st, vt[i].rdy);
            #1;
            chk($sformatf("vec%0d_if_flush", i), {31'b0, if_flush}, {31'b0, vt[i].f});
            chk($sformatf("vec%0d_id_flush", i), {31'b0, id_flush}, {31'b0, vt[i].f});
            chk($sformatf("vec%0d_halted", i), {31'b0, halted}, {31'b0, vt[i].h});
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_pc", i), pc, vt[i].pc);
            chk($sformatf("vec%0d_pc_plus4", i), pc_plus4, vt[i].pc + 32'd4);
            chk($sformatf("vec%0d_misalign_err", i), {31'b0, misalign_err}, {31'b0, vt[i].e});
        end

        // The table ends with a reset cycle, so the model starts from reset values.
        m_pc = RV; m_err = 1'b0; m_halt = 1'b0; m_quiet = 0;

        // Branch requested every cycle: only one per shadow window may be taken.
        for (int k = 0; k < 10; k++) begin
            model_cycle(1'b1, 2'b01, 32'h1000 + 32'(k) * 32'h100, 32'h0, k[0], 1'b1);
        end

        for (int n = 0; n < 2000; n++) begin
            logic        r;
            logic [1:0]  bc;
            logic [31:0] bt;
            logic [31:0] alu;
            logic        st;
            logic        rdy;
            r   = ($urandom_range(0, 24) != 0);
            bc  = 2'($urandom_range(0, 3));
            bt  = $urandom;
            alu = $urandom;
            if ($urandom_range(0, 7) != 0) bt[1:0] = 2'b00;
            if ($urandom_range(0, 7) != 0) alu[1] = 1'b0;
            if ($urandom_range(0, 15) == 0) bt = 32'hFFFF_FFFC;
            st  = ($urandom_range(0, 3) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            model_cycle(r, bc, bt, alu, st, rdy);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
